// File: rtl/rr_mux_pkg.sv
// Shared definitions for the 4:1 round-robin packet multiplexer.
package rr_mux_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_e;

   // Index of the set bit in a one-hot channel vector (0 when none is set).
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NCH-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arb4
   import rr_mux_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic [NCH-1:0]   grant_oh
);

   logic [SEL_W-1:0] idx;
   logic             found;

   // Walk channels ptr, ptr+1, ... (2-bit wrap) and grant the first requester.
   always_comb begin
      grant_oh = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx = ptr + SEL_W'(k);
         if (!found && req[idx]) begin
            grant_oh[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux4.sv
// Four valid/ready packet streams merged onto one registered output stream,
// round-robin arbitrated and locked to a channel until its last beat.
module rr_mux4
   import rr_mux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_last,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] lock_q, lock_d;
   logic             ovalid_q, ovalid_d;
   logic [WIDTH-1:0] odata_q, odata_d;
   logic             olast_q, olast_d;
   logic [SEL_W-1:0] osel_q, osel_d;

   logic             load_en;
   logic [NCH-1:0]   arb_grant;
   logic [NCH-1:0]   grant_oh;
   logic [SEL_W-1:0] gidx;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   rr_arb4 u_arb (
      .req      (in_valid),
      .ptr      (ptr_q),
      .grant_oh (arb_grant)
   );

   // Grant selection, ready generation and data mux for the granted channel.
   // in_ready is also held low while reset is asserted so nothing is accepted.
   always_comb begin
      load_en  = ~ovalid_q | out_ready;
      grant_oh = (state_q == LOCK) ? (NCH'(1) << lock_q) : arb_grant;
      in_ready = grant_oh & {NCH{load_en & ~rst}};
      xfer     = |(in_ready & in_valid);
      gidx     = onehot_to_idx(grant_oh);
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant_oh[i]) begin
            sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            sel_last = sel_last | in_last[i];
         end
      end
   end

   // Next-state: FSM, pointer, lock channel and output stage load.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      lock_d   = lock_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      olast_d  = olast_q;
      osel_d   = osel_q;
      if (load_en) ovalid_d = xfer;
      if (xfer) begin
         odata_d = sel_data;
         olast_d = sel_last;
         osel_d  = gidx;
         if (sel_last) begin
            state_d = ARB;
            ptr_d   = gidx + SEL_W'(1);
         end else begin
            state_d = LOCK;
            lock_d  = gidx;
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB;
         ptr_q    <= '0;
         lock_q   <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         olast_q  <= 1'b0;
         osel_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         lock_q   <= lock_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
         olast_q  <= olast_d;
         osel_q   <= osel_d;
      end
   end

   assign out_valid = ovalid_q;
   assign out_data  = odata_q;
   assign out_last  = olast_q;
   assign out_sel   = osel_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Scoreboard bench for rr_mux4: directed scenarios followed by random traffic.
module tb_rr_mux4;

   logic        clk;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_sel;
   logic        out_ready;

   int total = 0;
   int bad   = 0;

   // expected beat: {sel[1:0], last, data[7:0]}
   logic [10:0] sb_q[$];

   // reference model state
   int m_lock;   // locked channel, -1 when arbitrating
   int m_ptr;
   bit m_full;

   rr_mux4 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lock = -1;
      m_ptr  = 0;
      m_full = 1'b0;
   endtask

   // Predict in_ready and the accepted beat for the currently driven inputs.
   task automatic model_step();
      bit         load;
      logic [3:0] er;
      int         pick;
      int         c;
      load = !m_full || out_ready;
      er   = 4'b0000;
      if (load) begin
         if (m_lock >= 0) begin
            er[m_lock] = 1'b1;
         end else begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (pick < 0 && in_valid[c]) pick = c;
            end
            if (pick >= 0) er[pick] = 1'b1;
         end
      end
      chk("in_ready", {28'd0, in_ready}, {28'd0, er});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      pick = -1;
      for (int k = 0; k < 4; k++) if (er[k] && in_valid[k]) pick = k;
      if (pick >= 0) begin
         sb_q.push_back({2'(pick), in_last[pick], in_data[pick*8 +: 8]});
         if (in_last[pick]) begin
            m_lock = -1;
            m_ptr  = (pick + 1) % 4;
         end else begin
            m_lock = pick;
         end
      end
      if (load) m_full = (pick >= 0);
   endtask

   task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      #1;
      model_step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
      chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
      sb_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      in_valid = 4'b0000;
      rst      = 1'b0;
   endtask

   // Monitor: every output handshake pops and compares one expected beat.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty got=unexpected beat sel=%0d data=%0h exp=none at %0t",
                        out_sel, out_data, $time);
            end else begin
               e = sb_q.pop_front();
               chk("out_sel", {30'd0, out_sel}, {30'd0, e[10:9]});
               chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
               chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill the output stage and hold it, then reset mid-stream.
      cyc(4'b0001, 32'h000000AA, 4'b0001, 1'b0);
      cyc(4'b0001, 32'h000000AB, 4'b0001, 1'b0);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      do_reset();

      // Round-robin fairness with single-beat packets.
      for (int n = 0; n < 5; n++) begin
         cyc(4'b1111, 32'h13121110, 4'b1111, 1'b1);
         chk("rr_order", {28'd0, in_ready}, 32'd1 << (n % 4));
      end

      // Channel 1 locked for a 3-beat packet while others request.
      cyc(4'b1111, 32'h1312A010, 4'b1101, 1'b1);
      chk("lock_b0", {28'd0, in_ready}, 32'h2);
      cyc(4'b1111, 32'h1312A110, 4'b1101, 1'b1);
      chk("lock_b1", {28'd0, in_ready}, 32'h2);
      cyc(4'b1111, 32'h1312A210, 4'b1111, 1'b1);
      chk("lock_b2", {28'd0, in_ready}, 32'h2);
      cyc(4'b1111, 32'h13B01110, 4'b1011, 1'b1);
      chk("after_lock", {28'd0, in_ready}, 32'h4);

      // Channel 2 mid-packet stalls while channel 0 requests.
      for (int n = 0; n < 3; n++) begin
         cyc(4'b0001, 32'h13B01110, 4'b1111, 1'b1);
         chk("stall_ready", {28'd0, in_ready}, 32'h4);
      end
      cyc(4'b0101, 32'h13B11110, 4'b0101, 1'b1);
      chk("stall_resume", {28'd0, in_ready}, 32'h4);

      // Backpressure with a full output stage.
      for (int n = 0; n < 5; n++) begin
         cyc(4'b1001, 32'hC0121110, 4'b1111, 1'b0);
         chk("bp_ready", {28'd0, in_ready}, 32'h0);
      end

      // Channel 3 packet ends, pointer wraps to channel 0.
      cyc(4'b1001, 32'hC0121110, 4'b0001, 1'b1);
      chk("wrap_c3a", {28'd0, in_ready}, 32'h8);
      cyc(4'b1001, 32'hC1121110, 4'b1001, 1'b1);
      chk("wrap_c3b", {28'd0, in_ready}, 32'h8);
      cyc(4'b1001, 32'hC2121110, 4'b1001, 1'b1);
      chk("wrap_c0", {28'd0, in_ready}, 32'h1);

      // Random traffic with one reset in the middle.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] v;
         logic [3:0] l;
         for (int c = 0; c < 4; c++) begin
            v[c] = ($urandom_range(0, 3) != 0);
            l[c] = ($urandom_range(0, 2) == 0);
         end
         cyc(v, $urandom, l, ($urandom_range(0, 3) != 0));
         if (n == 1500) do_reset();
      end

      // Drain and confirm every accepted beat came out.
      repeat (4) cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
